// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the alu_seq execute stage.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_INC = 4'd5;
  localparam logic [3:0] OP_DEC = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  // Opcodes at or above this value are illegal: done pulses, nothing else changes.
  localparam logic [3:0] OP_FIRST_ILLEGAL = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiply datapath: load latches operands, each step consumes one
// multiplier bit. product_nxt is the accumulator value after the current step,
// so the caller can capture the final product on the edge that completes it.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product_nxt
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign product_nxt = mplier[0] ? (acc + mcand) : acc;
  assign last        = (cnt == CW'(WIDTH - 1));

  // Operand latch on load, one shift-add iteration per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
      cnt    <= '0;
    end else if (step) begin
      acc    <= product_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// 8-bit execute stage: single-cycle ops complete one edge after accept, MUL
// runs WIDTH shift-add steps. All outputs are registered.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   ST_IDLE | waiting for start; single-cycle ops complete here
//   ST_MUL  | multiply in progress, busy=1, start ignored
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             flag_load,
  output logic             wb_en
);

  state_t state, state_nxt;

  logic             mul_load, mul_step, mul_last;
  logic [2*WIDTH-1:0] product_nxt;

  logic [WIDTH:0]   sum_ab, diff_ab;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;

  logic [WIDTH-1:0] result_nxt;
  logic             carry_nxt, done_nxt, flag_nxt, wb_nxt;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk         (clk),
    .rst         (rst),
    .load        (mul_load),
    .step        (mul_step),
    .a           (a),
    .b           (b),
    .last        (mul_last),
    .product_nxt (product_nxt)
  );

  assign busy    = (state == ST_MUL);
  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign diff_ab = {1'b0, a} - {1'b0, b};

  // Single-cycle datapath; the top bit of diff_ab is the unsigned borrow.
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    case (op)
      OP_ADD: begin sc_res = sum_ab[WIDTH-1:0];  sc_carry = sum_ab[WIDTH];  end
      OP_SUB,
      OP_CMP: begin sc_res = diff_ab[WIDTH-1:0]; sc_carry = diff_ab[WIDTH]; end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_INC: begin sc_res = a + 1'b1; sc_carry = &a;  end
      OP_DEC: begin sc_res = a - 1'b1; sc_carry = ~|a; end
      OP_SHL: begin sc_res = {a[WIDTH-2:0], 1'b0}; sc_carry = a[WIDTH-1]; end
      OP_SHR: begin sc_res = {1'b0, a[WIDTH-1:1]}; sc_carry = a[0];       end
      default: ;
    endcase
  end

  // Next-state and next values for the output registers.
  always_comb begin
    state_nxt  = state;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    result_nxt = result;
    carry_nxt  = carry_out;
    done_nxt   = 1'b0;
    flag_nxt   = 1'b0;
    wb_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mul_load  = 1'b1;
            state_nxt = ST_MUL;
          end else if (op >= OP_FIRST_ILLEGAL) begin
            done_nxt = 1'b1;
          end else begin
            result_nxt = sc_res;
            carry_nxt  = sc_carry;
            done_nxt   = 1'b1;
            flag_nxt   = 1'b1;
            wb_nxt     = (op != OP_CMP);
          end
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          state_nxt  = ST_IDLE;
          result_nxt = product_nxt[WIDTH-1:0];
          carry_nxt  = |product_nxt[2*WIDTH-1:WIDTH];
          done_nxt   = 1'b1;
          flag_nxt   = 1'b1;
          wb_nxt     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      result    <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
      flag_load <= 1'b0;
      wb_en     <= 1'b0;
    end else begin
      state     <= state_nxt;
      result    <= result_nxt;
      carry_out <= carry_nxt;
      done      <= done_nxt;
      flag_load <= flag_nxt;
      wb_en     <= wb_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases plus random traffic against a
// transaction-level reference model.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, flag_load, wb_en;
  logic [W-1:0] result;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_result, m_carry, m_done, m_fl, m_wb;
  int mul_left, mul_prod;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .flag_load (flag_load),
    .wb_en     (wb_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit s, input int o, input int x, input int y);
    start = s;
    op    = 4'(o);
    a     = W'(x);
    b     = W'(y);
  endtask

  // Model the effect of one rising edge with the current inputs.
  task automatic model_edge();
    int av, bv, r, c;
    av = int'(a);
    bv = int'(b);
    m_done = 0; m_fl = 0; m_wb = 0;
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        m_result = mul_prod & MASK;
        m_carry  = (mul_prod > MASK) ? 1 : 0;
        m_done = 1; m_fl = 1; m_wb = 1;
      end
    end else if (start) begin
      if (op == 4'd10) begin
        mul_left = W;
        mul_prod = av * bv;
      end else if (op > 4'd10) begin
        m_done = 1;
      end else begin
        r = 0; c = 0;
        case (op)
          4'd0: begin r = av + bv; c = (av + bv > MASK) ? 1 : 0; end
          4'd1, 4'd7: begin r = av - bv; c = (av < bv) ? 1 : 0; end
          4'd2: r = av & bv;
          4'd3: r = av | bv;
          4'd4: r = av ^ bv;
          4'd5: begin r = av + 1; c = (av == MASK) ? 1 : 0; end
          4'd6: begin r = av - 1; c = (av == 0) ? 1 : 0; end
          4'd8: begin r = av * 2; c = (av >= (1 << (W - 1))) ? 1 : 0; end
          4'd9: begin r = av / 2; c = av % 2; end
          default: ;
        endcase
        m_result = r & MASK;
        m_carry  = c;
        m_done = 1; m_fl = 1;
        m_wb = (op != 4'd7) ? 1 : 0;
      end
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".result"}, 32'(result),    m_result);
    chk({tag, ".carry"},  32'(carry_out), m_carry);
    chk({tag, ".done"},   32'(done),      m_done);
    chk({tag, ".flag"},   32'(flag_load), m_fl);
    chk({tag, ".wb"},     32'(wb_en),     m_wb);
    chk({tag, ".busy"},   32'(busy),      (mul_left > 0) ? 1 : 0);
  endtask

  // One clock: edge with current inputs, then compare at the falling edge.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    m_result = 0; m_carry = 0; m_done = 0; m_fl = 0; m_wb = 0;
    mul_left = 0; mul_prod = 0;
    cmp_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0);
    #1;
    do_reset("por");

    // ADD with carry, then pulses drop
    drive(1, 0, 'hF0, 'h20); cyc("add");
    chk("add_res", 32'(result), 'h10);
    chk("add_c", 32'(carry_out), 1);
    drive(0, 0, 0, 0); cyc("add_idle");
    chk("add_done_drop", 32'(done), 0);

    // SUB with borrow, then illegal op holds result
    drive(1, 1, 'h05, 'h07); cyc("sub");
    chk("sub_res", 32'(result), 'hFE);
    chk("sub_c", 32'(carry_out), 1);
    drive(1, 'hF, 'h12, 'h34); cyc("ill");
    chk("ill_done", 32'(done), 1);
    chk("ill_fl", 32'(flag_load), 0);
    chk("ill_res", 32'(result), 'hFE);

    // CMP: flags only
    drive(1, 7, 'h42, 'h42); cyc("cmp");
    chk("cmp_res", 32'(result), 0);
    chk("cmp_fl", 32'(flag_load), 1);
    chk("cmp_wb", 32'(wb_en), 0);
    drive(0, 0, 0, 0); cyc("cmp_idle");

    // MUL 13*11: busy for 8 cycles, done on the 8th
    drive(1, 10, 13, 11); cyc("mul1_acc");
    drive(0, 0, 0, 0);
    for (int i = 0; i < W - 1; i++) begin
      cyc("mul1_run");
      chk("mul1_busy", 32'(busy), 1);
    end
    cyc("mul1_end");
    chk("mul1_res", 32'(result), 'h8F);
    chk("mul1_c", 32'(carry_out), 0);
    chk("mul1_busy0", 32'(busy), 0);

    // MUL 0x20*0x10 with ADD held on start throughout
    drive(1, 10, 'h20, 'h10); cyc("mul2_acc");
    drive(1, 0, 3, 4);
    for (int i = 0; i < W - 1; i++) cyc("mul2_run");
    cyc("mul2_end");
    chk("mul2_res", 32'(result), 0);
    chk("mul2_c", 32'(carry_out), 1);
    cyc("add_after_mul");
    chk("add_after_mul_res", 32'(result), 7);
    drive(0, 0, 0, 0); cyc("gap");

    // back-to-back single-cycle ops
    drive(1, 5, 'hFF, 0); cyc("b2b_inc");
    chk("inc_res", 32'(result), 0);
    drive(1, 6, 'h00, 0); cyc("b2b_dec");
    chk("dec_res", 32'(result), 'hFF);
    drive(1, 8, 'h81, 0); cyc("b2b_shl");
    chk("shl_res", 32'(result), 'h02);
    drive(1, 9, 'h01, 0); cyc("b2b_shr");
    chk("shr_res", 32'(result), 0);
    chk("shr_c", 32'(carry_out), 1);
    chk("b2b_done", 32'(done), 1);
    drive(0, 0, 0, 0); cyc("b2b_end");

    // reset in the middle of MUL 15*15 after 4 steps, then ADD
    drive(1, 10, 15, 15); cyc("rmul_acc");
    drive(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("rmul_run");
    do_reset("mid_mul_rst");
    drive(1, 0, 'h11, 'h22); cyc("post_rst_add");
    chk("post_rst_add_res", 32'(result), 'h33);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
            int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
      cyc("rand");
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < W + 2; i++) cyc("drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
